// File: rtl/fp_seq_ctrl.sv
// Sequencer for a multi-cycle FP unit: it stalls the pipeline, issues a start pulse, waits
// for FPDone or a timeout, then gates the register write and counts completed operations.
module fp_seq_ctrl #(
  parameter int TIMEOUT = 16,
  parameter int CNTW    = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            FPInstr,
  input  logic            FPOpIn,
  input  logic            RegWriteIn,
  input  logic            FPDone,
  output logic            FPStart,
  output logic            FPOp,
  output logic            Stall,
  output logic            RegWrite,
  output logic            FPBusy,
  output logic            FPErr,
  output logic [CNTW-1:0] FPCount
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    WB    = 2'd3
  } state_t;

  localparam logic [7:0]      TMO_LAST = 8'(TIMEOUT - 1);
  localparam logic [CNTW-1:0] CNT_MAX  = {CNTW{1'b1}};
  localparam logic [CNTW-1:0] CNT_ONE  = {{(CNTW-1){1'b0}}, 1'b1};

  state_t          state_q, state_d;
  logic [7:0]      cnt_q, cnt_d;
  logic            fpop_q, fpop_d;
  logic            err_q, err_d;
  logic            tmo_q, tmo_d;
  logic [CNTW-1:0] count_q, count_d;
  logic            start_s, stall_s, regwr_s;

  // State and datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      fpop_q  <= 1'b0;
      err_q   <= 1'b0;
      tmo_q   <= 1'b0;
      count_q <= {CNTW{1'b0}};
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      fpop_q  <= fpop_d;
      err_q   <= err_d;
      tmo_q   <= tmo_d;
      count_q <= count_d;
    end
  end

  // Next-state and control decode; tmo_q remembers whether the current op timed out
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    fpop_d  = fpop_q;
    err_d   = err_q;
    tmo_d   = tmo_q;
    count_d = count_q;
    start_s = 1'b0;
    stall_s = 1'b0;
    regwr_s = 1'b0;
    case (state_q)
      IDLE: begin
        if (FPInstr) begin
          stall_s = 1'b1;
          fpop_d  = FPOpIn;
          state_d = START;
        end else begin
          regwr_s = RegWriteIn;
        end
      end
      START: begin
        start_s = 1'b1;
        stall_s = 1'b1;
        cnt_d   = 8'd0;
        tmo_d   = 1'b0;
        state_d = WAIT;
      end
      WAIT: begin
        stall_s = 1'b1;
        cnt_d   = cnt_q + 8'd1;
        if (FPDone) begin
          state_d = WB;
        end else if (cnt_q == TMO_LAST) begin
          state_d = WB;
          err_d   = 1'b1;
          tmo_d   = 1'b1;
        end else begin
          state_d = WAIT;
        end
      end
      WB: begin
        regwr_s = RegWriteIn & ~tmo_q;
        if (count_q != CNT_MAX) begin
          count_d = count_q + CNT_ONE;
        end else begin
          count_d = count_q;
        end
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Reset forces the FSM to IDLE, so only the input-dependent IDLE terms need explicit gating
  assign FPStart  = start_s & ~reset;
  assign Stall    = stall_s & ~reset;
  assign RegWrite = regwr_s & ~reset;
  assign FPBusy   = (state_q == START) || (state_q == WAIT);
  assign FPOp     = fpop_q;
  assign FPErr    = err_q;
  assign FPCount  = count_q;

endmodule

// File: tb/tb_fp_seq_ctrl.sv
// Directed bench for fp_seq_ctrl (TIMEOUT=16, CNTW=4) with hand-computed expectations.
module tb_fp_seq_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       FPInstr, FPOpIn, RegWriteIn, FPDone;
  logic       FPStart, FPOp, Stall, RegWrite, FPBusy, FPErr;
  logic [3:0] FPCount;

  int passes = 0;
  int total  = 0;

  fp_seq_ctrl #(.TIMEOUT(16), .CNTW(4)) dut (
    .clk(clk), .reset(reset), .FPInstr(FPInstr), .FPOpIn(FPOpIn),
    .RegWriteIn(RegWriteIn), .FPDone(FPDone), .FPStart(FPStart), .FPOp(FPOp),
    .Stall(Stall), .RegWrite(RegWrite), .FPBusy(FPBusy), .FPErr(FPErr),
    .FPCount(FPCount)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Issues an FP op from IDLE with FPDone in WAIT cycle k (k=0: never); returns in WB.
  task automatic fp_op(input logic op, input int k);
    FPInstr = 1'b1;
    FPOpIn  = op;
    tick();
    FPInstr = 1'b0;
    repeat (k == 0 ? 16 : k) tick();
    FPDone = (k != 0);
    tick();
    FPDone = 1'b0;
  endtask

  initial begin
    reset = 1'b1; FPInstr = 1'b1; FPOpIn = 1'b1; RegWriteIn = 1'b1; FPDone = 1'b0;
    #2;
    chk("rst_stall", 32'(Stall), 32'd0);
    chk("rst_regwr", 32'(RegWrite), 32'd0);
    chk("rst_start", 32'(FPStart), 32'd0);
    chk("rst_busy",  32'(FPBusy), 32'd0);
    chk("rst_err",   32'(FPErr), 32'd0);
    chk("rst_op",    32'(FPOp), 32'd0);
    chk("rst_cnt",   32'(FPCount), 32'd0);
    tick();
    reset = 1'b0; FPInstr = 1'b0; FPOpIn = 1'b0;

    for (int i = 0; i < 5; i++) begin
      #1;
      chk("int_stall", 32'(Stall), 32'd0);
      chk("int_regwr", 32'(RegWrite), 32'd1);
      tick();
    end
    chk("int_cnt", 32'(FPCount), 32'd0);

    // Basic op: FPOpIn=1, FPDone in the 3rd WAIT cycle, stray FPDone in START
    FPInstr = 1'b1; FPOpIn = 1'b1;
    #1;
    chk("idle_fp_stall", 32'(Stall), 32'd1);
    chk("idle_fp_regwr", 32'(RegWrite), 32'd0);
    chk("idle_fp_start", 32'(FPStart), 32'd0);
    tick();
    FPInstr = 1'b0; FPOpIn = 1'b0; FPDone = 1'b1;
    chk("start_pulse", 32'(FPStart), 32'd1);
    chk("start_stall", 32'(Stall), 32'd1);
    chk("start_op",    32'(FPOp), 32'd1);
    chk("start_busy",  32'(FPBusy), 32'd1);
    tick();
    FPDone = 1'b0;
    chk("wait1_busy",  32'(FPBusy), 32'd1);
    chk("wait1_start", 32'(FPStart), 32'd0);
    chk("wait1_stall", 32'(Stall), 32'd1);
    tick();
    tick();
    FPDone = 1'b1;
    chk("wait3_stall", 32'(Stall), 32'd1);
    chk("wait3_op",    32'(FPOp), 32'd1);
    tick();
    FPDone = 1'b0;
    chk("wb_stall", 32'(Stall), 32'd0);
    chk("wb_regwr", 32'(RegWrite), 32'd1);
    chk("wb_busy",  32'(FPBusy), 32'd0);
    chk("wb_op",    32'(FPOp), 32'd1);
    tick();
    chk("op1_cnt", 32'(FPCount), 32'd1);
    chk("op1_err", 32'(FPErr), 32'd0);
    chk("op1_idle_regwr", 32'(RegWrite), 32'd1);

    // FPDone coincides with the last allowed WAIT cycle: success, no error
    fp_op(1'b0, 16);
    chk("edge_regwr", 32'(RegWrite), 32'd1);
    chk("edge_err",   32'(FPErr), 32'd0);
    chk("edge_op",    32'(FPOp), 32'd0);
    tick();
    chk("edge_cnt", 32'(FPCount), 32'd2);

    // Timeout: 16 WAIT cycles, write suppressed, sticky error
    FPInstr = 1'b1;
    tick();
    FPInstr = 1'b0;
    repeat (16) tick();
    chk("tmo_w16_busy", 32'(FPBusy), 32'd1);
    chk("tmo_w16_err",  32'(FPErr), 32'd0);
    tick();
    chk("tmo_wb_stall", 32'(Stall), 32'd0);
    chk("tmo_wb_regwr", 32'(RegWrite), 32'd0);
    chk("tmo_wb_err",   32'(FPErr), 32'd1);
    tick();
    chk("tmo_cnt", 32'(FPCount), 32'd3);

    fp_op(1'b1, 2);
    chk("post_tmo_regwr", 32'(RegWrite), 32'd1);
    chk("post_tmo_err",   32'(FPErr), 32'd1);
    tick();
    chk("post_tmo_cnt", 32'(FPCount), 32'd4);

    // Reset in the 2nd WAIT cycle aborts the op
    FPInstr = 1'b1;
    tick();
    FPInstr = 1'b0;
    tick();
    tick();
    reset = 1'b1; FPInstr = 1'b1; RegWriteIn = 1'b1;
    #1;
    chk("abort_stall", 32'(Stall), 32'd0);
    chk("abort_regwr", 32'(RegWrite), 32'd0);
    chk("abort_busy",  32'(FPBusy), 32'd0);
    chk("abort_cnt",   32'(FPCount), 32'd0);
    chk("abort_err",   32'(FPErr), 32'd0);
    chk("abort_op",    32'(FPOp), 32'd0);
    tick();
    reset = 1'b0;
    #1;
    chk("rel_stall", 32'(Stall), 32'd1);
    tick();
    FPInstr = 1'b0; FPDone = 1'b1;
    chk("rel_start", 32'(FPStart), 32'd1);
    tick();
    tick();
    FPDone = 1'b0;
    chk("rel_wb_regwr", 32'(RegWrite), 32'd1);
    tick();
    chk("rel_cnt", 32'(FPCount), 32'd1);

    // Stray FPDone in IDLE has no effect
    FPDone = 1'b1;
    tick();
    FPDone = 1'b0;
    chk("stray_busy",  32'(FPBusy), 32'd0);
    chk("stray_stall", 32'(Stall), 32'd0);
    chk("stray_cnt",   32'(FPCount), 32'd1);

    // 17 more ops push the 4-bit counter past 15
    for (int i = 0; i < 13; i++) begin
      fp_op(1'b1, 1);
      tick();
    end
    chk("cnt_14", 32'(FPCount), 32'd14);
    for (int i = 0; i < 4; i++) begin
      fp_op(1'b1, 1);
      tick();
    end
    chk("cnt_sat", 32'(FPCount), 32'd15);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "bench timeout");
  end

endmodule
